// File: rtl/char_buf_pkg.sv
// Shared types and default placement constants for the character buffer loader.
package char_buf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DONE
    } state_t;

    localparam int unsigned DEF_BASE_ADDR = 1500;
    localparam int unsigned DEF_LEN_ADDR  = 1499;
    localparam int unsigned DEF_DEPTH     = 108;

endpackage

// File: rtl/char_buffer_loader_if.sv
// Valid/ready character stream from the host source into the loader.
interface char_buffer_loader_if #(
    parameter int unsigned CHAR_W = 8
);
    logic              in_valid;
    logic [CHAR_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/char_buf_mem_mux.sv
// RAM write-port select: loader writes win; a colliding CPU write is dropped and flagged.
module char_buf_mem_mux #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic              loader_we,
    input  logic [ADDR_W-1:0] loader_addr,
    input  logic [DATA_W-1:0] loader_data,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              conflict
);

    always_comb begin
        conflict = loader_we && cpu_we;
        if (loader_we) begin
            mem_we   = 1'b1;
            mem_addr = loader_addr;
            mem_data = loader_data;
        end else begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_data = cpu_data;
        end
    end

endmodule

// File: rtl/char_buffer_loader.sv
// Streams host characters into a RAM region, then commits the message length to a header word.
module char_buffer_loader
    import char_buf_pkg::*;
#(
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned LEN_ADDR  = DEF_LEN_ADDR,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned CHAR_W    = 8,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    char_buffer_loader_if.slave          in_if,
    input  logic                         clear,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_data,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         done,
    output logic                         overflow,
    output logic                         cpu_conflict
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_depth_check
        $error("char_buffer_loader: DEPTH must be at least 1");
    end
    if (DATA_W < CHAR_W) begin : g_width_check
        $error("char_buffer_loader: DATA_W must be at least CHAR_W");
    end
    if (longint'(BASE_ADDR) + longint'(DEPTH) - 1 >= (longint'(1) << ADDR_W)) begin : g_wrap_check
        $error("char_buffer_loader: character region wraps the address space");
    end

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              ready, accept, last_slot;
    logic              ld_we, conflict;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              overflow_q, conflict_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, LOAD: if (accept) state_nx = (in_if.in_last || last_slot) ? COMMIT : LOAD;
                COMMIT:     state_nx = DONE;
                DONE:       state_nx = DONE;
                default:    state_nx = IDLE;
            endcase
        end
    end

    // clear suppresses both the accept and a pending length commit in the same cycle
    always_comb begin
        ready     = ((state == IDLE) || (state == LOAD)) && (cnt < CNT_W'(DEPTH)) && !clear;
        accept    = in_if.in_valid && ready;
        last_slot = (cnt == CNT_W'(DEPTH - 1));
        ld_we     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        if (accept) begin
            ld_we   = 1'b1;
            ld_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt);
            ld_data = DATA_W'(in_if.in_data);
        end else if ((state == COMMIT) && !clear) begin
            ld_we   = 1'b1;
            ld_addr = ADDR_W'(LEN_ADDR);
            ld_data = DATA_W'(cnt);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            overflow_q <= 1'b0;
            conflict_q <= 1'b0;
        end else if (clear) begin
            cnt        <= '0;
            overflow_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            if (accept) cnt <= cnt + CNT_W'(1);
            if ((state == DONE) && in_if.in_valid) overflow_q <= 1'b1;
            if (conflict) conflict_q <= 1'b1;
        end
    end

    char_buf_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .loader_we   (ld_we),
        .loader_addr (ld_addr),
        .loader_data (ld_data),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .conflict    (conflict)
    );

    assign in_if.in_ready = ready;
    assign count          = cnt;
    assign done           = (state == DONE);
    assign overflow       = overflow_q;
    assign cpu_conflict   = conflict_q;

endmodule

// File: tb/tb_char_buffer_loader.sv
// Directed bench for char_buffer_loader: default instance plus a DEPTH=4 instance at base 100.
module tb_char_buffer_loader;

    logic        clock;
    logic        reset;
    logic        clear, clear2;
    logic        cpu_we, cpu_we2;
    logic [11:0] cpu_addr, cpu_addr2;
    logic [31:0] cpu_data, cpu_data2;
    logic        mem_we, mem_we2;
    logic [11:0] mem_addr, mem_addr2;
    logic [31:0] mem_data, mem_data2;
    logic [6:0]  count;
    logic [2:0]  count2;
    logic        done, done2, overflow, overflow2, cpu_conflict, cpu_conflict2;

    logic [31:0] ram  [0:4095];
    logic [31:0] ram2 [0:4095];

    int checks = 0;
    int errors = 0;

    char_buffer_loader_if #(.CHAR_W(8)) s_if ();
    char_buffer_loader_if #(.CHAR_W(8)) s2_if ();

    char_buffer_loader u_dut (
        .clock (clock), .reset (reset), .in_if (s_if), .clear (clear),
        .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_data (cpu_data),
        .mem_we (mem_we), .mem_addr (mem_addr), .mem_data (mem_data),
        .count (count), .done (done), .overflow (overflow), .cpu_conflict (cpu_conflict)
    );

    char_buffer_loader #(.BASE_ADDR(100), .LEN_ADDR(99), .DEPTH(4)) u_small (
        .clock (clock), .reset (reset), .in_if (s2_if), .clear (clear2),
        .cpu_we (cpu_we2), .cpu_addr (cpu_addr2), .cpu_data (cpu_data2),
        .mem_we (mem_we2), .mem_addr (mem_addr2), .mem_data (mem_data2),
        .count (count2), .done (done2), .overflow (overflow2), .cpu_conflict (cpu_conflict2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) if (mem_we)  ram[mem_addr]   <= mem_data;
    always @(posedge clock) if (mem_we2) ram2[mem_addr2] <= mem_data2;

    task automatic pulse_clear();
        @(negedge clock); clear = 1'b1;
        @(negedge clock); clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; clear2 = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.in_last = 1'b0;
        s2_if.in_valid = 1'b0; s2_if.in_data = '0; s2_if.in_last = 1'b0;
        cpu_we2 = 1'b0; cpu_addr2 = '0; cpu_data2 = '0;
        cpu_we = 1'b1; cpu_addr = 12'd5; cpu_data = 32'd7;
        #12;
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        checks++; if (cpu_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %0b expected 0", cpu_conflict); end
        checks++; if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", s_if.in_ready); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 12'd5 || mem_data !== 32'd7) begin errors++; $display("FAIL reset_passthru: got we=%0b addr=%0d data=%0d expected we=1 addr=5 data=7", mem_we, mem_addr, mem_data); end
        checks++; if (count2 !== 3'd0 || s2_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_small: got count=%0d ready=%0b expected 0 1", count2, s2_if.in_ready); end
        cpu_we = 1'b0;
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_hello();
        logic [7:0] msg [5];
        msg = '{8'd72, 8'd69, 8'd76, 8'd76, 8'd79};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            s_if.in_valid = 1'b1; s_if.in_data = msg[i]; s_if.in_last = (i == 4);
            #1;
            checks++; if (mem_we !== 1'b1 || mem_addr !== 12'(1500 + i) || mem_data !== 32'(msg[i])) begin errors++; $display("FAIL hello_write%0d: got we=%0b addr=%0d data=%0d expected 1 %0d %0d", i, mem_we, mem_addr, mem_data, 1500 + i, msg[i]); end
        end
        @(negedge clock); s_if.in_valid = 1'b0; s_if.in_last = 1'b0; #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 12'd1499 || mem_data !== 32'd5) begin errors++; $display("FAIL hello_commit: got we=%0b addr=%0d data=%0d expected 1 1499 5", mem_we, mem_addr, mem_data); end
        checks++; if (done !== 1'b0 || count !== 7'd5) begin errors++; $display("FAIL hello_commit_state: got done=%0b count=%0d expected 0 5", done, count); end
        @(negedge clock); #1;
        checks++; if (done !== 1'b1 || s_if.in_ready !== 1'b0) begin errors++; $display("FAIL hello_done: got done=%0b ready=%0b expected 1 0", done, s_if.in_ready); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (ram[1500 + i] !== 32'(msg[i])) begin errors++; $display("FAIL hello_ram%0d: got %0d expected %0d", i, ram[1500 + i], msg[i]); end
        end
        checks++; if (ram[1499] !== 32'd5) begin errors++; $display("FAIL hello_len: got %0d expected 5", ram[1499]); end
    endtask

    task automatic test_depth_overflow();
        pulse_clear(); #1;
        checks++; if (count !== 7'd0 || done !== 1'b0) begin errors++; $display("FAIL depth_clear: got count=%0d done=%0b expected 0 0", count, done); end
        for (int i = 0; i < 108; i++) begin
            @(negedge clock);
            s_if.in_valid = 1'b1; s_if.in_data = 8'(i + 10); s_if.in_last = 1'b0;
            if (i == 107) begin
                #1;
                checks++; if (s_if.in_ready !== 1'b1 || mem_addr !== 12'd1607) begin errors++; $display("FAIL depth_last_slot: got ready=%0b addr=%0d expected 1 1607", s_if.in_ready, mem_addr); end
            end
        end
        @(negedge clock); s_if.in_valid = 1'b0; #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 12'd1499 || mem_data !== 32'd108) begin errors++; $display("FAIL depth_auto_commit: got we=%0b addr=%0d data=%0d expected 1 1499 108", mem_we, mem_addr, mem_data); end
        checks++; if (s_if.in_ready !== 1'b0 || count !== 7'd108) begin errors++; $display("FAIL depth_full: got ready=%0b count=%0d expected 0 108", s_if.in_ready, count); end
        @(negedge clock); s_if.in_valid = 1'b1; s_if.in_data = 8'hFF; #1;
        checks++; if (done !== 1'b1 || mem_we !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL depth_done: got done=%0b we=%0b ovf=%0b expected 1 0 0", done, mem_we, overflow); end
        @(negedge clock); s_if.in_valid = 1'b0; #1;
        checks++; if (overflow !== 1'b1 || count !== 7'd108) begin errors++; $display("FAIL depth_overflow: got ovf=%0b count=%0d expected 1 108", overflow, count); end
        checks++; if (ram[1499] !== 32'd108 || ram[1500] !== 32'd10 || ram[1607] !== 32'd117) begin errors++; $display("FAIL depth_ram: got len=%0d first=%0d last=%0d expected 108 10 117", ram[1499], ram[1500], ram[1607]); end
    endtask

    task automatic test_cpu_conflict();
        pulse_clear(); #1;
        checks++; if (overflow !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL conflict_clear: got ovf=%0b done=%0b expected 0 0", overflow, done); end
        @(negedge clock); cpu_we = 1'b1; cpu_addr = 12'd20; cpu_data = 32'h1234; #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 12'd20 || mem_data !== 32'h1234) begin errors++; $display("FAIL cpu_idle_write: got we=%0b addr=%0d data=%h expected 1 20 1234", mem_we, mem_addr, mem_data); end
        @(negedge clock); cpu_data = 32'hDEAD; s_if.in_valid = 1'b1; s_if.in_data = 8'd65; #1;
        checks++; if (ram[20] !== 32'h1234 || cpu_conflict !== 1'b0) begin errors++; $display("FAIL cpu_idle_result: got ram=%h conflict=%0b expected 1234 0", ram[20], cpu_conflict); end
        checks++; if (mem_addr !== 12'd1500 || mem_data !== 32'd65) begin errors++; $display("FAIL cpu_masked: got addr=%0d data=%0d expected 1500 65", mem_addr, mem_data); end
        @(negedge clock); cpu_we = 1'b0; s_if.in_valid = 1'b0; #1;
        checks++; if (ram[20] !== 32'h1234 || cpu_conflict !== 1'b1) begin errors++; $display("FAIL cpu_conflict: got ram=%h conflict=%0b expected 1234 1", ram[20], cpu_conflict); end
        checks++; if (ram[1500] !== 32'd65 || count !== 7'd1) begin errors++; $display("FAIL conflict_accept: got ram=%0d count=%0d expected 65 1", ram[1500], count); end
    endtask

    task automatic test_clear();
        pulse_clear(); #1;
        checks++; if (cpu_conflict !== 1'b0) begin errors++; $display("FAIL clear_conflict_flag: got %0b expected 0", cpu_conflict); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); s_if.in_valid = 1'b1; s_if.in_data = 8'(97 + i); s_if.in_last = 1'b0;
        end
        @(negedge clock); s_if.in_data = 8'd100; clear = 1'b1; #1;
        checks++; if (s_if.in_ready !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL clear_beats_valid: got ready=%0b we=%0b expected 0 0", s_if.in_ready, mem_we); end
        @(negedge clock); clear = 1'b0; s_if.in_valid = 1'b0; #1;
        checks++; if (count !== 7'd0 || done !== 1'b0 || s_if.in_ready !== 1'b1) begin errors++; $display("FAIL clear_state: got count=%0d done=%0b ready=%0b expected 0 0 1", count, done, s_if.in_ready); end
        @(negedge clock); #1;
        checks++; if (ram[1499] !== 32'd108 || ram[1503] === 32'd100) begin errors++; $display("FAIL clear_no_commit: got len=%0d ram1503=%0d expected 108 and not 100", ram[1499], ram[1503]); end
        @(negedge clock); s_if.in_valid = 1'b1; s_if.in_data = 8'd120; s_if.in_last = 1'b1; #1;
        checks++; if (mem_addr !== 12'd1500) begin errors++; $display("FAIL clear_restart_addr: got %0d expected 1500", mem_addr); end
        @(negedge clock); s_if.in_valid = 1'b0; s_if.in_last = 1'b0;
        @(negedge clock); #1;
        checks++; if (done !== 1'b1 || ram[1499] !== 32'd1 || ram[1500] !== 32'd120) begin errors++; $display("FAIL clear_restart_msg: got done=%0b len=%0d c0=%0d expected 1 1 120", done, ram[1499], ram[1500]); end
    endtask

    task automatic test_async_reset();
        pulse_clear();
        for (int i = 0; i < 7; i++) begin
            @(negedge clock); s_if.in_valid = 1'b1; s_if.in_data = 8'(65 + i); s_if.in_last = 1'b0;
        end
        @(negedge clock); s_if.in_valid = 1'b0; #1;
        checks++; if (count !== 7'd7) begin errors++; $display("FAIL areset_pre_count: got %0d expected 7", count); end
        #2 reset = 1'b0; #1;
        checks++; if (count !== 7'd0 || s_if.in_ready !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL areset_immediate: got count=%0d ready=%0b done=%0b we=%0b expected 0 1 0 0", count, s_if.in_ready, done, mem_we); end
        checks++; if (u_dut.state !== char_buf_pkg::IDLE) begin errors++; $display("FAIL areset_state: got %0d expected %0d", u_dut.state, char_buf_pkg::IDLE); end
        @(negedge clock); reset = 1'b1;
        @(negedge clock); #1;
        checks++; if (done !== 1'b0 || count !== 7'd0 || ram[1499] !== 32'd1) begin errors++; $display("FAIL areset_after: got done=%0b count=%0d len=%0d expected 0 0 1", done, count, ram[1499]); end
    endtask

    task automatic test_small_depth();
        @(negedge clock); s2_if.in_valid = 1'b1; s2_if.in_data = 8'd11; s2_if.in_last = 1'b0; #1;
        checks++; if (mem_we2 !== 1'b1 || mem_addr2 !== 12'd100) begin errors++; $display("FAIL small_addr0: got we=%0b addr=%0d expected 1 100", mem_we2, mem_addr2); end
        @(negedge clock); s2_if.in_data = 8'd22; s2_if.in_last = 1'b1; #1;
        checks++; if (mem_addr2 !== 12'd101) begin errors++; $display("FAIL small_addr1: got %0d expected 101", mem_addr2); end
        @(negedge clock); s2_if.in_valid = 1'b0; s2_if.in_last = 1'b0; #1;
        checks++; if (mem_addr2 !== 12'd99 || mem_data2 !== 32'd2) begin errors++; $display("FAIL small_commit: got addr=%0d data=%0d expected 99 2", mem_addr2, mem_data2); end
        @(negedge clock); #1;
        checks++; if (done2 !== 1'b1 || ram2[100] !== 32'd11 || ram2[101] !== 32'd22 || ram2[99] !== 32'd2) begin errors++; $display("FAIL small_msg: got done=%0b r100=%0d r101=%0d r99=%0d expected 1 11 22 2", done2, ram2[100], ram2[101], ram2[99]); end
        @(negedge clock); clear2 = 1'b1;
        @(negedge clock); clear2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); s2_if.in_valid = 1'b1; s2_if.in_data = 8'(i + 1);
        end
        @(negedge clock); s2_if.in_valid = 1'b0; #1;
        checks++; if (mem_addr2 !== 12'd99 || mem_data2 !== 32'd4 || s2_if.in_ready !== 1'b0) begin errors++; $display("FAIL small_auto_commit: got addr=%0d data=%0d ready=%0b expected 99 4 0", mem_addr2, mem_data2, s2_if.in_ready); end
        @(negedge clock); #1;
        checks++; if (done2 !== 1'b1 || ram2[99] !== 32'd4 || ram2[103] !== 32'd4) begin errors++; $display("FAIL small_full: got done=%0b r99=%0d r103=%0d expected 1 4 4", done2, ram2[99], ram2[103]); end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_depth_overflow();
        test_cpu_conflict();
        test_clear();
        test_async_reset();
        test_small_depth();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
